// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked RV32I-style ALU with an iterative 1-bit-per-cycle shifter
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] reg_source1,
    input  logic [WIDTH-1:0] reg_source2,
    input  logic [WIDTH-1:0] imm_source,
    input  logic             imm,
    input  logic [2:0]       oper,
    input  logic             alt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic             shift_left;
    logic             shift_arith;

    logic [WIDTH-1:0] b_sel;
    logic [SHW-1:0]   amount;
    logic             is_shift;
    logic [WIDTH-1:0] alu_res;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign zero      = (res == '0);

    // Operand selection and single-cycle result; shift ops only load operand a here
    always_comb begin
        b_sel    = imm ? imm_source : reg_source2;
        amount   = b_sel[SHW-1:0];
        is_shift = (oper == 3'b001) || (oper == 3'b101);
        alu_res  = '0;
        case (oper)
            3'b000:  alu_res = (alt && !imm) ? (reg_source1 - b_sel) : (reg_source1 + b_sel);
            3'b010:  alu_res[0] = ($signed(reg_source1) < $signed(b_sel));
            3'b011:  alu_res[0] = (reg_source1 < b_sel);
            3'b100:  alu_res = reg_source1 ^ b_sel;
            3'b110:  alu_res = reg_source1 | b_sel;
            3'b111:  alu_res = reg_source1 & b_sel;
            default: alu_res = reg_source1;
        endcase
    end

    // Control FSM: accept in IDLE, shift one bit per cycle in SHIFT, hold result in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            res         <= '0;
            cnt         <= '0;
            shift_left  <= 1'b0;
            shift_arith <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        res <= alu_res;
                        if (is_shift && (amount != '0)) begin
                            cnt         <= amount;
                            shift_left  <= (oper == 3'b001);
                            shift_arith <= alt;
                            state       <= SHIFT;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (shift_left) begin
                        res <= {res[WIDTH-2:0], 1'b0};
                    end else begin
                        res <= {shift_arith & res[WIDTH-1], res[WIDTH-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a behavioural reference model
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] reg_source1;
    logic [31:0] reg_source2;
    logic [31:0] imm_source;
    logic        imm;
    logic [2:0]  oper;
    logic        alt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        zero;

    int pass_cnt = 0;
    int total    = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .reg_source1 (reg_source1),
        .reg_source2 (reg_source2),
        .imm_source  (imm_source),
        .imm         (imm),
        .oper        (oper),
        .alt         (alt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .res         (res),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    // Reference result straight from the RV32I operation definitions
    function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                              input logic im, input logic [2:0] op, input logic al);
        int n;
        n = int'(b % 32);
        case (op)
            3'd0: return (al && !im) ? a - b : a + b;
            3'd1: return a << n;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return al ? 32'($signed(a) >>> n) : a >> n;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int model_lat(input logic [31:0] b, input logic [2:0] op);
        if (op == 3'd1 || op == 3'd5) return int'(b % 32) + 1;
        return 1;
    endfunction

    // Issue one operation, wait for the result, then complete it with out_ready
    task automatic do_op(input logic [31:0] a, input logic [31:0] b2, input logic [31:0] iv,
                         input logic im, input logic [2:0] op, input logic al,
                         output logic [31:0] r, output logic z, output int lat, output logic rdy_after);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        reg_source1 = a; reg_source2 = b2; imm_source = iv; imm = im; oper = op; alt = al;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        r = res;
        z = zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rdy_after = in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total++; if (res !== 32'h0) $display("FAIL reset_res: got %h expected 00000000", res); else pass_cnt++;
        total++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b expected 1", zero); else pass_cnt++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        reg_source1 = 32'h5; reg_source2 = 32'h7; imm = 1'b0; oper = 3'd0; alt = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_priority: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [31:0] r; logic z; int lat; logic rd;
        do_op(32'h5, 32'h7, 32'h3, 1'b0, 3'd0, 1'b0, r, z, lat, rd);
        total++; if (r !== 32'hC || lat != 1) $display("FAIL add: got %h lat %0d expected 0000000c lat 1", r, lat); else pass_cnt++;
        total++; if (rd !== 1'b1) $display("FAIL add_ready_after: got %b expected 1", rd); else pass_cnt++;
        do_op(32'h5, 32'h7, 32'h3, 1'b0, 3'd0, 1'b1, r, z, lat, rd);
        total++; if (r !== 32'hFFFF_FFFE) $display("FAIL sub: got %h expected fffffffe", r); else pass_cnt++;
        do_op(32'h5, 32'h7, 32'h3, 1'b1, 3'd0, 1'b1, r, z, lat, rd);
        total++; if (r !== 32'h8) $display("FAIL addi_alt: got %h expected 00000008", r); else pass_cnt++;
        do_op(32'h5, 32'h7, 32'h3, 1'b0, 3'd7, 1'b0, r, z, lat, rd);
        total++; if (r !== 32'h5) $display("FAIL and: got %h expected 00000005", r); else pass_cnt++;
        do_op(32'h5, 32'h7, 32'h3, 1'b0, 3'd6, 1'b0, r, z, lat, rd);
        total++; if (r !== 32'h7) $display("FAIL or: got %h expected 00000007", r); else pass_cnt++;
        do_op(32'h5, 32'h7, 32'h3, 1'b0, 3'd4, 1'b0, r, z, lat, rd);
        total++; if (r !== 32'h2 || z !== 1'b0) $display("FAIL xor: got %h zero %b expected 00000002 zero 0", r, z); else pass_cnt++;
        do_op(32'h5, 32'h5, 32'h3, 1'b0, 3'd4, 1'b0, r, z, lat, rd);
        total++; if (r !== 32'h0 || z !== 1'b1) $display("FAIL xor_self: got %h zero %b expected 00000000 zero 1", r, z); else pass_cnt++;
    endtask

    task automatic test_compare();
        logic [31:0] r; logic z; int lat; logic rd;
        do_op(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 3'd2, 1'b0, r, z, lat, rd);
        total++; if (r !== 32'h1) $display("FAIL slt: got %h expected 00000001", r); else pass_cnt++;
        do_op(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 3'd3, 1'b0, r, z, lat, rd);
        total++; if (r !== 32'h0) $display("FAIL sltu: got %h expected 00000000", r); else pass_cnt++;
    endtask

    task automatic test_shifts();
        logic [31:0] r; logic z; int lat; logic rd;
        do_op(32'h8000_0001, 32'h4, 32'h0, 1'b0, 3'd5, 1'b1, r, z, lat, rd);
        total++; if (r !== 32'hF800_0000 || lat != 5) $display("FAIL sra4: got %h lat %0d expected f8000000 lat 5", r, lat); else pass_cnt++;
        do_op(32'h8000_0001, 32'h0, 32'h4, 1'b1, 3'd5, 1'b0, r, z, lat, rd);
        total++; if (r !== 32'h0800_0000 || lat != 5) $display("FAIL srli4: got %h lat %0d expected 08000000 lat 5", r, lat); else pass_cnt++;
        do_op(32'h8000_0001, 32'd31, 32'h0, 1'b0, 3'd1, 1'b0, r, z, lat, rd);
        total++; if (r !== 32'h8000_0000 || lat != 32) $display("FAIL sll31: got %h lat %0d expected 80000000 lat 32", r, lat); else pass_cnt++;
        do_op(32'h8000_0001, 32'h20, 32'h0, 1'b0, 3'd1, 1'b0, r, z, lat, rd);
        total++; if (r !== 32'h8000_0001 || lat != 1) $display("FAIL sll_n0: got %h lat %0d expected 80000001 lat 1", r, lat); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] r; logic z; int lat; logic rd;
        logic [31:0] a, b2, iv, bsel, exp_r;
        logic im, al;
        logic [2:0] op;
        int exp_lat;
        for (int i = 0; i < 40; i++) begin
            a  = $urandom; b2 = $urandom; iv = $urandom;
            if (i % 4 == 0) b2 = a;
            im = 1'($urandom_range(0, 1));
            al = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            bsel    = im ? iv : b2;
            exp_r   = model_res(a, bsel, im, op, al);
            exp_lat = model_lat(bsel, op);
            do_op(a, b2, iv, im, op, al, r, z, lat, rd);
            total++;
            if (r !== exp_r || lat != exp_lat || z !== (exp_r == 32'h0))
                $display("FAIL random_%0d op%0d alt%0d imm%0d: got %h lat %0d zero %b expected %h lat %0d",
                         i, op, al, im, r, lat, z, exp_r, exp_lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int guard = 0;
        logic stable = 1'b1;
        reg_source1 = 32'h10; reg_source2 = 32'h22; imm = 1'b0; oper = 3'd0; alt = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        reg_source1 = 32'h100; reg_source2 = 32'h3;
        while (!out_valid && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        held = res;
        total++; if (held !== 32'h32) $display("FAIL bp_result: got %h expected 00000032", held); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (res !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        total++; if (stable !== 1'b1 || res !== held) $display("FAIL bp_hold: got stable=%b res %h expected stable=1 res %h", stable, res, held); else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || res !== 32'h103) $display("FAIL bp_next_op: got out_valid=%b res %h expected 1 00000103", out_valid, res); else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nvalid = 0;
        logic good = 1'b1;
        reg_source1 = 32'hA; reg_source2 = 32'h1; imm = 1'b0; oper = 3'd6; alt = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                nvalid++;
                if (res !== 32'hB) good = 1'b0;
            end
            if (out_valid && in_ready) good = 1'b0;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++; if (nvalid != 5 || good !== 1'b1) $display("FAIL back_to_back: got %0d results good=%b expected 5 good=1", nvalid, good); else pass_cnt++;
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_idle: got in_ready=%b expected 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] r; logic z; int lat; logic rd;
        logic seen = 1'b0;
        reg_source1 = 32'h8000_0001; reg_source2 = 32'd20; imm = 1'b0; oper = 3'd1; alt = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (seen !== 1'b0 || out_valid !== 1'b0) $display("FAIL rst_mid_valid: got seen=%b out_valid=%b expected 0/0", seen, out_valid); else pass_cnt++;
        total++; if (res !== 32'h0 || in_ready !== 1'b1) $display("FAIL rst_mid_state: got res %h in_ready %b expected 00000000 1", res, in_ready); else pass_cnt++;
        do_op(32'h5, 32'h7, 32'h0, 1'b0, 3'd0, 1'b0, r, z, lat, rd);
        total++; if (r !== 32'hC || lat != 1) $display("FAIL rst_mid_add: got %h lat %0d expected 0000000c lat 1", r, lat); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        reg_source1 = '0; reg_source2 = '0; imm_source = '0; imm = 1'b0; oper = '0; alt = 1'b0;
        test_reset();
        test_arith();
        test_compare();
        test_shifts();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
